alu_pipe: RTL and testbench

//  Parametrised, registered successor to the 8-bit combinational ALU.
//  - Keeps the legacy opcodes ADD/SUB/AND/OR/MOV with the same encoding.
//  - Adds XOR, SHL and an iterative multi-cycle MUL, plus Z/N/C/V flags.
//  - Valid/ready handshakes on the input and output sides.
//  - Sits between register-file read and writeback in the CPU datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 49 ++++
 rtl/alu_pipe.sv | 128 ++++++++++++
 tb/tb_alu_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bundle and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MOV = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier; one partial product per clock, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The final step's sum is exposed combinationally so the top can load it on the same edge.
  assign done    = (r_cnt == CNT_W'(1));
  assign product = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, Z/N/C/V flags and an iterative multiply.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e         r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  alu_flags_t         r_flags;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic               w_load;
  logic [2*WIDTH-1:0] w_mul_product;
  alu_op_e            w_op;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_flags;

  // Returns {carry, shifted}; carry is the last bit shifted out, zero for s==0 or s>=WIDTH.
  function automatic logic [WIDTH:0] shl_with_carry(input logic [WIDTH-1:0] val,
                                                    input logic [SH_W-1:0]  s);
    logic [WIDTH:0] ext;
    ext = {1'b0, val} << s;
    if (int'(s) >= WIDTH) ext = '0;
    return ext;
  endfunction

  assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (alu_op_e'(op) == OP_MUL);
  assign w_load      = (w_accept && !w_mul_start) || ((r_state == ST_MUL) && w_mul_done);
  assign w_op        = (r_state == ST_MUL) ? OP_MUL : alu_op_e'(op);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_shl   = shl_with_carry(a, b[SH_W-1:0]);
    w_res   = '0;
    w_flags = '0;
    unique case (w_op)
      OP_ADD: begin
        w_res     = w_sum[WIDTH-1:0];
        w_flags.c = w_sum[WIDTH];
        w_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res     = a - b;
        w_flags.c = (a < b);
        w_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_MOV: w_res = b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        w_res     = w_shl[WIDTH-1:0];
        w_flags.c = w_shl[WIDTH];
      end
      OP_MUL: begin
        w_res     = w_mul_product[WIDTH-1:0];
        w_flags.c = |w_mul_product[2*WIDTH-1:WIDTH];
      end
      default: w_res = '0;
    endcase
    w_flags.z = (w_res == '0);
    w_flags.n = w_res[WIDTH-1];
  end

  // Output slot: a freshly loaded result takes priority over draining the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      if (w_mul_start) begin
        r_state <= ST_MUL;
      end else if ((r_state == ST_MUL) && w_mul_done) begin
        r_state <= ST_IDLE;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_flags     <= w_flags;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and scoreboarded bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         MOV = 3'd4, XOR_ = 3'd5, SHL = 3'd6, MUL = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [11:0] sb_q[$];
  int          pop_cyc[$];
  logic [11:0] exp_v;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Independent reference: integer arithmetic, returns {result, Z, N, C, V}.
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int r = 0;
    int c = 0;
    int v = 0;
    int s = 0;
    logic [7:0] r8;
    case (o)
      ADD: begin r = ux + uy; c = (r > 255); v = ((sx + sy) > 127) || ((sx + sy) < -128); end
      SUB: begin r = ux - uy; c = (ux < uy); v = ((sx - sy) > 127) || ((sx - sy) < -128); end
      AND_: r = ux & uy;
      OR_:  r = ux | uy;
      MOV:  r = uy;
      XOR_: r = ux ^ uy;
      SHL: begin s = uy % 8; r = ux << s; c = (s == 0) ? 0 : ((ux >> (8 - s)) & 1); end
      default: begin r = ux * uy; c = (r > 255); end
    endcase
    r8 = 8'(r & 255);
    return {r8, (r8 == 8'd0), r8[7], (c != 0), (v != 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [11:0] e, input bit push);
    int waited = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("accept_wait", (waited < 50), 1);
    @(posedge clk);
    if (push) sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_result: observed %h expected none", {result, flags});
      end
      if (sb_q.size() != 0) begin
        exp_v = sb_q.pop_front();
        assert ({result, flags} === exp_v) else begin
          n_fail++;
          $error("FAIL result_flags: observed %h expected %h", {result, flags}, exp_v);
        end
      end
    end
  end

  initial begin
    logic [2:0] ro;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    issue(ADD, 8'hFF, 8'h01, {8'h00, 4'b1010}, 1);
    check("add_latency", out_valid, 1);
    issue(ADD, 8'h7F, 8'h01, {8'h80, 4'b0101}, 1);
    issue(SUB, 8'h03, 8'h05, {8'hFE, 4'b0110}, 1);
    issue(SHL, 8'h81, 8'h01, {8'h02, 4'b0010}, 1);

    issue(MUL, 8'h10, 8'h11, {8'h10, 4'b0010}, 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mul_in_ready_%0d", k), in_ready, 0);
      check($sformatf("mul_out_valid_%0d", k), out_valid, 0);
      @(posedge clk);
      #1;
    end
    check("mul_latency", out_valid, 1);
    issue(MUL, 8'h03, 8'h05, {8'h0F, 4'b0000}, 1);

    issue(XOR_, 8'hA5, 8'h5A, model(XOR_, 8'hA5, 8'h5A), 1);
    issue(AND_, 8'hF0, 8'h3C, model(AND_, 8'hF0, 8'h3C), 1);
    issue(OR_, 8'h00, 8'h00, model(OR_, 8'h00, 8'h00), 1);
    issue(MOV, 8'h12, 8'h9C, model(MOV, 8'h12, 8'h9C), 1);
    issue(SUB, 8'h55, 8'h55, model(SUB, 8'h55, 8'h55), 1);
    issue(SUB, 8'h80, 8'h01, model(SUB, 8'h80, 8'h01), 1);
    issue(ADD, 8'h80, 8'h80, model(ADD, 8'h80, 8'h80), 1);
    issue(SHL, 8'h81, 8'h07, model(SHL, 8'h81, 8'h07), 1);
    issue(SHL, 8'hC3, 8'hF8, model(SHL, 8'hC3, 8'hF8), 1);
    issue(MUL, 8'hFF, 8'hFF, model(MUL, 8'hFF, 8'hFF), 1);
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      issue(ro, ra, rb, model(ro, ra, rb), 1);
    end
    wait_drain();

    out_ready = 1'b0;
    issue(ADD, 8'h12, 8'h34, {8'h46, 4'b0000}, 1);
    op = ADD; a = 8'h40; b = 8'h40; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      check($sformatf("bp_hold_result_%0d", k), result, 8'h46);
      check($sformatf("bp_hold_valid_%0d", k), out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    sb_q.push_back({8'h80, 4'b0101});
    #1;
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_result", result, 8'h80);
    wait_drain();

    pop_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      ra = 8'(i * 17 + 3);
      rb = 8'(i * 5 + 200);
      issue(ADD, ra, rb, model(ADD, ra, rb), 1);
    end
    wait_drain();
    check("stream_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++) check($sformatf("stream_gap_%0d", i), pop_cyc[i+1] - pop_cyc[i], 1);
    end

    issue(MUL, 8'h07, 8'h09, 12'h000, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("abort_rst_valid_%0d", k), out_valid, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abort_no_valid_%0d", k), out_valid, 0);
      @(posedge clk);
      #1;
    end
    issue(ADD, 8'h05, 8'h06, {8'h0B, 4'b0000}, 1);
    check("post_abort_valid", out_valid, 1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
